mips_rtype_seq: RTL and testbench
=================================

# mips_rtype_seq

Multi-cycle R-type execution sequencer that drives the MIPS register file as its initiator. It accepts one 32-bit R-type instruction per valid/ready handshake, issues the two read addresses, captures the operands, and computes the ALU result. It then drives the write port (address, data, write enable) for one cycle and reports flags. It sits between the instruction source (testbench or fetch logic) and the two-read/one-write register file.

## Interface
Parameters:
- none; widths are fixed (32-bit data, 5-bit register addresses).

Ports:
- Clk  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Instr  in  32  R-type instruction: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct.
- Instr_Valid  in  1  Instr is valid this cycle.
- Instr_Ready  out  1  sequencer can accept; high only in IDLE and only while Reset is low.
- R_Addr_C  out  5  register file read address A, carries rs.
- R_Addr_B  out  5  register file read address B, carries rt.
- R_Data_C  in  32  register file read data A; combinational read, r0 reads 0.
- R_Data_B  in  32  register file read data B.
- W_Addr  out  5  write address, carries rd.
- W_Data  out  32  write data, equals Result.
- Write_Reg  out  1  write enable; one-cycle pulse.
- Result  out  32  last computed result; held until the next EXEC.
- ZF  out  1  Result == 0.
- OF  out  1  signed overflow on add or sub.
- Err  out  1  unsupported op/funct.
- Done  out  1  one-cycle completion pulse.

## Operation
- State machine:
  - IDLE → READ when Instr_Valid && Instr_Ready; the instruction is latched into an internal register at that edge.
  - READ → EXEC unconditionally; operands A=R_Data_C and B=R_Data_B are latched at the READ→EXEC edge.
  - EXEC → WB unconditionally; Result, ZF, OF and Err are registered at this edge.
  - WB → IDLE unconditionally.
- R_Addr_C, R_Addr_B and W_Addr are driven continuously from the latched instruction fields.
- Supported operations (op must be 6'h00; anything else sets Err):
  - funct 20 add: signed add, sets OF.
  - funct 21 addu: add, OF=0.
  - funct 22 sub: signed subtract, sets OF.
  - funct 23 subu: subtract, OF=0.
  - funct 24 and; 25 or; 26 xor; 27 nor.
  - funct 2A slt: signed compare, result {31'b0, A<B}.
  - funct 2B sltu: unsigned compare.
  - funct 00 sll: B<<shamt; 02 srl: B>>shamt; 03 sra: arithmetic shift of B by shamt.
- Any other funct sets Err=1 and Result=0.
- Overflow rule: add OF = (A[31]==B[31]) && (S[31]!=A[31]); sub OF = (A[31]!=B[31]) && (S[31]!=A[31]). Result is the wrapped 32-bit sum/difference.
- Write_Reg = (state==WB) && !Err && !OF && (rd!=0).
- Done = (state==WB) regardless of Err, OF or rd.
- ZF is computed on the registered Result, including the Err case (Result=0 → ZF=1).
- Instr_Valid outside IDLE is ignored; there is no queuing.

## Timing
- Reset (synchronous): state=IDLE; latched instruction, operands, Result, ZF, OF and Err all 0.
  - Consequently R_Addr_C, R_Addr_B, W_Addr, W_Data = 0; Write_Reg=0 and Done=0.
  - Instr_Ready=0 while Reset is high, and 1 in the first cycle after Reset falls.
- Accept at edge E0.
  - Cycle E0–E1 (READ): read addresses valid.
  - Edge E1: operands captured.
  - Edge E2: result registered.
  - Cycle E2–E3 (WB): Write_Reg and Done high.
  - Edge E3: register file commits.
- Latency is 3 cycles from accept to the write edge; throughput is 1 instruction per 4 cycles.
- Instr_Ready returns high in the cycle after E3, so a back-to-back instruction can be accepted at E3+1 edge at the earliest.
- Its READ therefore sees the committed value; no forwarding is needed.
- Reset asserted in any state: returns to IDLE at that edge.
  - Write_Reg/Done are not emitted for the aborted instruction.
  - No partial write occurs, even if Reset lands in WB, because the register file is also reset.
- Result, flags and W_Data hold their values in IDLE until the next EXEC→WB edge.

## Test plan
- Reset, then write r1=7 and r2=5 via a bench preload; issue add r3,r1,r2 (0x00221820) → Write_Reg pulses exactly 3 cycles after accept with W_Addr=3, W_Data=12; Done=1 in the same cycle; ZF=0, OF=0.
- With r1=0x7FFFFFFF, r2=1, issue add r3,r1,r2 → OF=1, Result=0x80000000, Write_Reg stays 0, Done=1; the same operands with addu → write 0x80000000, OF=0.
- With r1=0xFFFFFFFF, r2=1: slt r4,r1,r2 → 1; sltu → 0; sra r5,r0,r1 with shamt=4 on r1=0x80000000 → 0xF8000000.
- Write with rd=0 (add r0,r1,r2) → Done=1, Write_Reg=0; r0 still reads 0.
- Unsupported funct 0x3F, and op=0x08 → Err=1, Result=0, ZF=1, no write.
- Back-to-back add r3,r1,r2 then add r4,r3,r3 with Instr_Valid held high → second accepted exactly 4 cycles after the first, r4=24; Reset asserted during EXEC of a third instruction → no Write_Reg/Done, Instr_Ready=1 one cycle after Reset falls.

Source files
------------

// File: rtl/mips_rtype_seq.sv
// mips_rtype_seq: multi-cycle R-type execution sequencer driving a
// two-read/one-write register file as its initiator.
//
// Handshake: an instruction transfers on a rising edge where Instr_Valid
// and Instr_Ready are both high. Instr_Ready is high only in IDLE while
// Reset is low. Valid is not required to be held and is ignored outside
// IDLE (no queuing).
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   Instr/_Valid/_Ready  instruction input handshake
//   R_Addr_C/R_Addr_B out  read addresses (rs, rt) from latched instruction
//   R_Data_C/R_Data_B in   combinational read data
//   W_Addr/W_Data/Write_Reg  write port (rd, Result, one-cycle enable)
//   Result, ZF, OF, Err    registered result and flags, held until next EXEC
//   Done                   one-cycle completion pulse in WB
//
// Sequence: IDLE -> READ (operands captured) -> EXEC (result registered)
//           -> WB (write + done) -> IDLE. The FSM state is held in state_q.
module mips_rtype_seq (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Instr_Valid,
  output logic        Instr_Ready,
  output logic [4:0]  R_Addr_C,
  output logic [4:0]  R_Addr_B,
  input  logic [31:0] R_Data_C,
  input  logic [31:0] R_Data_B,
  output logic [4:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_Reg,
  output logic [31:0] Result,
  output logic        ZF,
  output logic        OF,
  output logic        Err,
  output logic        Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        zf_q, zf_d;
  logic        of_q, of_d;
  logic        err_q, err_d;

  // Instruction fields
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign funct = instr_q[5:0];

  // ALU, evaluated from the captured operands
  logic [31:0] sum, diff, alu_res;
  logic        alu_of, alu_err;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    alu_res = 32'd0;
    alu_of  = 1'b0;
    alu_err = 1'b0;
    if (op != 6'h00) begin
      alu_err = 1'b1;
    end else begin
      case (funct)
        6'h20: begin
          alu_res = sum;
          alu_of  = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
        end
        6'h21: alu_res = sum;
        6'h22: begin
          alu_res = diff;
          alu_of  = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
        end
        6'h23: alu_res = diff;
        6'h24: alu_res = a_q & b_q;
        6'h25: alu_res = a_q | b_q;
        6'h26: alu_res = a_q ^ b_q;
        6'h27: alu_res = ~(a_q | b_q);
        6'h2A: alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
        6'h2B: alu_res = {31'd0, (a_q < b_q)};
        6'h00: alu_res = b_q << shamt;
        6'h02: alu_res = b_q >> shamt;
        6'h03: alu_res = $signed(b_q) >>> shamt;
        default: alu_err = 1'b1;
      endcase
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zf_d     = zf_q;
    of_d     = of_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (Instr_Valid) begin
          instr_d = Instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = R_Data_C;
        b_d     = R_Data_B;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_res;
        zf_d     = (alu_res == 32'd0);
        of_d     = alu_of;
        err_d    = alu_err;
        state_d  = S_WB;
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      instr_q  <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
      zf_q     <= 1'b0;
      of_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      of_q     <= of_d;
      err_q    <= err_d;
    end
  end

  assign Instr_Ready = (state_q == S_IDLE) && !Reset;
  assign R_Addr_C    = rs;
  assign R_Addr_B    = rt;
  assign W_Addr      = rd;
  assign W_Data      = result_q;
  assign Result      = result_q;
  assign ZF          = zf_q;
  assign OF          = of_q;
  assign Err         = err_q;
  // Overflowing or failed results and writes to r0 are suppressed
  assign Write_Reg   = (state_q == S_WB) && !err_q && !of_q && (rd != 5'd0);
  assign Done        = (state_q == S_WB);

endmodule

// File: tb/tb_mips_rtype_seq.sv
// Bench for mips_rtype_seq: a register file model on the write/read ports,
// directed instructions with hand-computed expectations, and a write
// scoreboard fed by the driver.
module tb_mips_rtype_seq;

  localparam int W = 37; // {addr[4:0], data[31:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  r_addr_c, r_addr_b, w_addr;
  logic [31:0] r_data_c, r_data_b, w_data, result;
  logic        write_reg, zf, ovf, err, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mips_rtype_seq dut (
    .Clk(clk), .Reset(reset), .Instr(instr), .Instr_Valid(instr_valid),
    .Instr_Ready(instr_ready), .R_Addr_C(r_addr_c), .R_Addr_B(r_addr_b),
    .R_Data_C(r_data_c), .R_Data_B(r_data_b), .W_Addr(w_addr),
    .W_Data(w_data), .Write_Reg(write_reg), .Result(result), .ZF(zf),
    .OF(ovf), .Err(err), .Done(done)
  );

  // register file model with a bench preload port
  logic [31:0] rf [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  assign r_data_c = (r_addr_c == 5'd0) ? 32'd0 : rf[r_addr_c];
  assign r_data_b = (r_addr_b == 5'd0) ? 32'd0 : rf[r_addr_b];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (write_reg && w_addr != 5'd0) rf[w_addr] <= w_data;
      if (pl_en) rf[pl_addr] <= pl_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write pulse must match the next expected write
  always @(negedge clk) begin
    if (write_reg === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, w_addr, w_data}, 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_port", {27'd0, w_addr, w_data}, {27'd0, e});
      end
    end
  end

  // driver tasks
  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
  endtask

  // Issue one instruction and check the whole transaction at the WB cycle.
  task automatic run_instr(input string tag, input logic [31:0] ins,
                           input logic exp_we, input logic [31:0] exp_res,
                           input logic exp_zf, input logic exp_of,
                           input logic exp_err);
    int lat;
    @(negedge clk);
    wait_ready(tag);
    if (exp_we) exp_q.push_back({ins[15:11], exp_res});
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check({tag, "_raddr"}, {54'd0, r_addr_c, r_addr_b}, {54'd0, ins[25:21], ins[20:16]});
    lat = 1;
    while (done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_we"}, {63'd0, write_reg}, {63'd0, exp_we});
    check({tag, "_waddr"}, {59'd0, w_addr}, {59'd0, ins[15:11]});
    check({tag, "_result"}, {32'd0, result}, {32'd0, exp_res});
    check({tag, "_flags"}, {61'd0, zf, ovf, err}, {61'd0, exp_zf, exp_of, exp_err});
    @(negedge clk);
    check({tag, "_after_wb"}, {61'd0, done, write_reg, instr_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    int cyc;
    reset = 1'b1; instr = 32'd0; instr_valid = 1'b0;
    pl_en = 1'b0; pl_addr = 5'd0; pl_data = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, instr_ready}, 64'd0);
    check("reset_addrs", {49'd0, r_addr_c, r_addr_b, w_addr}, 64'd0);
    check("reset_outs", {26'd0, w_data, write_reg, done, zf, ovf, err, 1'b0}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    reset = 1'b0;
    #1 check("ready_after_reset", {63'd0, instr_ready}, 64'd1);

    // add / overflow / addu
    preload(5'd1, 32'd7);
    preload(5'd2, 32'd5);
    run_instr("add", 32'h00221820, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
    preload(5'd1, 32'h7FFFFFFF);
    preload(5'd2, 32'd1);
    run_instr("add_ovf", 32'h00221820, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_instr("addu", 32'h00221821, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0);

    // compares
    preload(5'd1, 32'hFFFFFFFF);
    run_instr("slt", 32'h0022202A, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    run_instr("sltu", 32'h0022202B, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);

    // shifts (B operand is rt)
    preload(5'd1, 32'h80000000);
    run_instr("sra", 32'h00012903, 1'b1, 32'hF8000000, 1'b0, 1'b0, 1'b0);
    run_instr("srl", 32'h00012902, 1'b1, 32'h08000000, 1'b0, 1'b0, 1'b0);
    run_instr("sll", 32'h00022900, 1'b1, 32'h00000010, 1'b0, 1'b0, 1'b0);

    // sub overflow / subu: 0x80000000 - 1
    run_instr("sub_ovf", 32'h00223022, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    run_instr("subu", 32'h00223023, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0);

    // logic ops
    preload(5'd1, 32'hF0F000FF);
    preload(5'd2, 32'h0FF00F0F);
    run_instr("and", 32'h00223824, 1'b1, 32'h00F0000F, 1'b0, 1'b0, 1'b0);
    run_instr("or",  32'h00223825, 1'b1, 32'hFFF00FFF, 1'b0, 1'b0, 1'b0);
    run_instr("xor", 32'h00223826, 1'b1, 32'hFF000FF0, 1'b0, 1'b0, 1'b0);
    run_instr("nor", 32'h00223827, 1'b1, 32'h000FF000, 1'b0, 1'b0, 1'b0);

    // rd = 0 and unsupported encodings
    preload(5'd1, 32'd7);
    preload(5'd2, 32'd5);
    run_instr("add_r0", 32'h00220020, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
    run_instr("bad_funct", 32'h0022183F, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    run_instr("bad_op", 32'h20221820, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);

    // back-to-back with valid held: add r3,r1,r2 then add r4,r3,r3
    @(negedge clk);
    wait_ready("b2b");
    exp_q.push_back({5'd3, 32'd12});
    exp_q.push_back({5'd4, 32'd24});
    instr = 32'h00221820; instr_valid = 1'b1;
    @(negedge clk);
    instr = 32'h00632020;
    cyc = 1;
    while (instr_ready !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_accept_spacing", 64'(cyc), 64'd4);
    @(negedge clk);
    instr_valid = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_latency", 64'(cyc), 64'd3);
    check("b2b_result", {32'd0, result}, 64'd24);
    @(negedge clk);

    // reset during EXEC aborts the instruction
    instr = 32'h00222820; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_reset", {61'd0, done, write_reg, instr_ready}, 64'd0);
    reset = 1'b0;
    #1 check("abort_ready", {63'd0, instr_ready}, 64'd1);
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1 || write_reg === 1'b1) cyc++;
    end
    check("abort_no_done", 64'(cyc), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
